// File: rtl/rate_clock_pkg.sv
// -----------------------------------------------------------------------------
// rate_clock_pkg
//   Shared types and elaboration-time helpers for the rate_clock_gen slice.
//   - len_t     : wide unsigned type used for half-period arithmetic, so that
//                 MIN_HALF + rate*STEP never overflows before it is compared.
//   - cnt_width : counter width able to hold the longest half period.
//   - half_len  : half-period length L for a given rate code.
// -----------------------------------------------------------------------------
package rate_clock_pkg;

  typedef logic [63:0] len_t;

  // Smallest width w with 2**w > longest L, i.e. $clog2(max_L + 1).
  // Written as a bounded loop so it stays a plain constant function.
  function automatic int cnt_width(input int rate_w, input int min_half,
                                   input int step);
    len_t max_len;
    int   w;
    max_len = len_t'(min_half)
            + ((len_t'(1) << rate_w) - len_t'(1)) * len_t'(step);
    w = 1;
    for (int i = 1; i < 64; i++) begin
      if ((len_t'(1) << i) <= max_len) w = i + 1;
    end
    return w;
  endfunction

  // Half-period length in clk cycles for one rate code.
  function automatic len_t half_len(input len_t rate, input len_t min_half,
                                    input len_t step);
    return min_half + rate * step;
  endfunction

endpackage

// File: rtl/rate_clock_ch.sv
// -----------------------------------------------------------------------------
// rate_clock_ch
//   One slow-clock channel: counts L = MIN_HALF + rate_lat*STEP enabled cycles
//   per half period, toggles slw_clk_o and pulses tick_o at each boundary.
//   The rate is re-sampled only at a boundary (or on sync), so a new code never
//   cuts short or stretches the half period already in progress.
// Ports
//   clk        in  system clock
//   reset      in  asynchronous, active-high reset
//   en_i       in  1: count, 0: freeze (tick forced low)
//   sync_i     in  synchronous restart: cnt=0, output high, rate re-sampled
//   rate_i     in  rate code for this channel
//   slw_clk_o  out registered square wave (resets high)
//   tick_o     out registered one-cycle pulse with each slw_clk_o toggle
// -----------------------------------------------------------------------------
module rate_clock_ch
  import rate_clock_pkg::*;
#(
  parameter int RATE_W   = 8,
  parameter int MIN_HALF = 2_500_000,
  parameter int STEP     = 88_235,
  parameter int CNT_W    = cnt_width(RATE_W, MIN_HALF, STEP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              sync_i,
  input  logic [RATE_W-1:0] rate_i,
  output logic              slw_clk_o,
  output logic              tick_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RATE_W-1:0] rate_lat_q, rate_lat_d;
  logic              slw_q, slw_d;
  logic              tick_q, tick_d;

  len_t len;
  logic last_cycle;

  // Compare in the wide domain: L-1 is always representable because L >= 1,
  // and the counter only ever runs on the latched rate, so it cannot pass L-1.
  assign len        = half_len(len_t'(rate_lat_q), len_t'(MIN_HALF), len_t'(STEP));
  assign last_cycle = (len_t'(cnt_q) == (len - len_t'(1)));

  always_comb begin
    // NOTE: every signal gets a hold/default value first, so no path through
    // the if-chain leaves one unassigned and no latch is inferred.
    cnt_d      = cnt_q;
    rate_lat_d = rate_lat_q;
    slw_d      = slw_q;
    tick_d     = 1'b0;

    if (sync_i) begin
      cnt_d      = '0;
      slw_d      = 1'b1;
      rate_lat_d = rate_i;
    end else if (en_i) begin
      if (last_cycle) begin
        cnt_d      = '0;
        slw_d      = ~slw_q;
        tick_d     = 1'b1;
        rate_lat_d = rate_i;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      rate_lat_q <= '0;
      slw_q      <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rate_lat_q <= rate_lat_d;
      slw_q      <= slw_d;
      tick_q     <= tick_d;
    end
  end

  assign slw_clk_o = slw_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/rate_clock_gen.sv
// -----------------------------------------------------------------------------
// rate_clock_gen
//   NCH-channel programmable slow-clock / tick generator for the LED pattern
//   engines. Each channel is an independent rate_clock_ch; the channels share
//   only the global enable and sync.
// Ports
//   clk      in  system clock
//   reset    in  asynchronous, active-high reset
//   en       in  1: channels count, 0: all channels freeze
//   sync     in  synchronous restart of every channel
//   rate     in  NCH*RATE_W; channel i code = rate[i*RATE_W +: RATE_W]
//   slw_clk  out NCH per-channel square waves
//   tick     out NCH per-channel toggle pulses
// -----------------------------------------------------------------------------
module rate_clock_gen
  import rate_clock_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int RATE_W   = 8,
  parameter int MIN_HALF = 2_500_000,
  parameter int STEP     = 88_235
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  sync,
  input  logic [NCH*RATE_W-1:0] rate,
  output logic [NCH-1:0]        slw_clk,
  output logic [NCH-1:0]        tick
);

  localparam int CNT_W = cnt_width(RATE_W, MIN_HALF, STEP);

  if (MIN_HALF < 1) begin : g_bad_min_half
    $error("rate_clock_gen: MIN_HALF must be >= 1");
  end
  if (NCH < 1) begin : g_bad_nch
    $error("rate_clock_gen: NCH must be >= 1");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    rate_clock_ch #(
      .RATE_W  (RATE_W),
      .MIN_HALF(MIN_HALF),
      .STEP    (STEP),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en_i     (en),
      .sync_i   (sync),
      .rate_i   (rate[i*RATE_W +: RATE_W]),
      .slw_clk_o(slw_clk[i]),
      .tick_o   (tick[i])
    );
  end

endmodule

// File: tb/tb_rate_clock_gen.sv
// -----------------------------------------------------------------------------
// tb_rate_clock_gen
//   Directed bench for rate_clock_gen with NCH=2, RATE_W=3, MIN_HALF=4, STEP=2
//   (L ranges 4..18). A per-cycle reference model pushes the expected outputs
//   into a scoreboard queue before each clock edge; they are popped and
//   compared one time unit after the edge. Directed checks on half-period
//   lengths, sync, enable and async reset sit on top of that.
// -----------------------------------------------------------------------------
module tb_rate_clock_gen;

  localparam int NCH      = 2;
  localparam int RATE_W   = 3;
  localparam int MIN_HALF = 4;
  localparam int STEP     = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  en;
  logic                  sync;
  logic [NCH*RATE_W-1:0] rate;
  logic [NCH-1:0]        slw_clk;
  logic [NCH-1:0]        tick;

  rate_clock_gen #(
    .NCH     (NCH),
    .RATE_W  (RATE_W),
    .MIN_HALF(MIN_HALF),
    .STEP    (STEP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .sync   (sync),
    .rate   (rate),
    .slw_clk(slw_clk),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] slw;
    logic [NCH-1:0] tick;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: counts down the cycles remaining in the half period.
  int   m_rem [NCH];
  int   m_lat [NCH];
  logic m_slw [NCH];
  logic m_tick[NCH];

  function automatic int len_of(input int r);
    return MIN_HALF + r * STEP;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_lat[c]  = 0;
      m_rem[c]  = len_of(0);
      m_slw[c]  = 1'b1;
      m_tick[c] = 1'b0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    exp_t e;
    for (int c = 0; c < NCH; c++) begin
      int r;
      r = int'(rate[c*RATE_W +: RATE_W]);
      m_tick[c] = 1'b0;
      if (sync) begin
        m_lat[c] = r;
        m_rem[c] = len_of(r);
        m_slw[c] = 1'b1;
      end else if (en) begin
        if (m_rem[c] == 1) begin
          m_slw[c]  = ~m_slw[c];
          m_tick[c] = 1'b1;
          m_lat[c]  = r;
          m_rem[c]  = len_of(r);
        end else begin
          m_rem[c] = m_rem[c] - 1;
        end
      end
      e.slw[c]  = m_slw[c];
      e.tick[c] = m_tick[c];
    end
    sb_q.push_back(e);
  endtask

  // One clock: push expectation, clock, pop and compare.
  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("sb", 32'({slw_clk, tick}), 32'(e));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until channel ch ticks; n = number of edges taken (bounded).
  task automatic run_until_tick(input int ch, output int n);
    logic got;
    got = 1'b0;
    n   = 0;
    while (!got && n < 64) begin
      step();
      n++;
      got = tick[ch];
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $error("FAIL tick_timeout: observed no tick on ch%0d expected tick within 64 cycles", ch);
    end
  endtask

  initial begin
    int n;
    int t0;
    int t1;

    reset = 1'b1;
    en    = 1'b0;
    sync  = 1'b0;
    rate  = '0;
    model_reset();

    // Reset state
    #12;
    check("reset_state", 32'({slw_clk, tick}), 32'h0000_000C);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1. rate 0: half periods of 4 cycles
    en = 1'b1;
    run_until_tick(0, n);
    check("t1_first_half", n, 4);
    check("t1_slw_low", 32'(slw_clk[0]), 32'd0);
    run_until_tick(0, n);
    check("t1_second_half", n, 4);
    check("t1_slw_high", 32'(slw_clk[0]), 32'd1);

    // 2. latch rate 7 (L=18), change to 0 mid half period
    rate[2:0] = 3'd7;
    run_until_tick(0, n);
    check("t2_old_rate_half", n, 4);
    steps(10);
    rate[2:0] = 3'd0;
    run_until_tick(0, n);
    check("t2_long_half_rest", n, 8);
    run_until_tick(0, n);
    check("t2_after_change_a", n, 4);
    run_until_tick(0, n);
    check("t2_after_change_b", n, 4);

    // 3. en=0 for 5 cycles at cnt=2: half period becomes L+5
    steps(2);
    en = 1'b0;
    steps(5);
    check("t3_frozen_no_tick", 32'(tick), 32'd0);
    en = 1'b1;
    run_until_tick(0, n);
    check("t3_stretched_half", 7 + n, 9);

    // 4. sync at cnt=3 while slw_clk[0]=0, rate0=5 (L=14)
    if (m_slw[0]) run_until_tick(0, n);
    steps(3);
    sync = 1'b1;
    rate[2:0] = 3'd5;
    step();
    sync = 1'b0;
    check("t4_sync_out", 32'({slw_clk[0], tick[0]}), 32'b10);
    run_until_tick(0, n);
    check("t4_sync_half", n, 14);

    // 4b. same with en=0 during sync
    steps(3);
    en   = 1'b0;
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("t4b_sync_out", 32'({slw_clk[0], tick[0]}), 32'b10);
    en = 1'b1;
    run_until_tick(0, n);
    check("t4b_sync_half", n, 14);

    // 5. async reset right after a tick (slw low, tick high)
    check("t5_pre_reset", 32'({slw_clk[0], tick[0]}), 32'b01);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t5_async_reset", 32'({slw_clk, tick}), 32'h0000_000C);
    #2;
    reset = 1'b0;
    run_until_tick(0, n);
    check("t5_first_half_rate0", n, 4);

    // 6. rate0=1 (L=6), rate1=3 (L=10) started together via sync
    sync = 1'b1;
    rate = {3'd3, 3'd1};
    step();
    sync = 1'b0;
    t0 = 0;
    t1 = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      t0 += int'(tick[0]);
      t1 += int'(tick[1]);
    end
    check("t6_ticks_ch0", t0, 10);
    check("t6_ticks_ch1", t1, 6);
    check("t6_in_phase", 32'({slw_clk, tick}), 32'h0000_000F);

    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
